// File: rtl/scope_cmd_pkg.sv
// Shared constants, state encoding and frame validation for the scope command controller.
package scope_cmd_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned DIV_W  = 16;

   localparam logic [BYTE_W-1:0] HDR          = 8'hA5;
   localparam logic [BYTE_W-1:0] CMD_SET_TRIG = 8'h01;
   localparam logic [BYTE_W-1:0] CMD_SET_TB   = 8'h02;
   localparam logic [BYTE_W-1:0] CMD_ARM      = 8'h03;
   localparam logic [BYTE_W-1:0] CMD_FORCE    = 8'h04;
   localparam logic [BYTE_W-1:0] CMD_DEFAULTS = 8'h05;
   localparam logic [BYTE_W-1:0] ACK_BYTE     = 8'h06;
   localparam logic [BYTE_W-1:0] NACK_BYTE    = 8'h15;

   localparam logic [BYTE_W-1:0] DEF_LEVEL = 8'h80;
   localparam logic              DEF_EDGE  = 1'b0;
   localparam logic [DIV_W-1:0]  DEF_DIV   = 16'h01B2;

   typedef enum logic [2:0] {IDLE, CMD, D0, D1, CHK, EXEC, RESP} state_t;

   // A frame is actionable only with a known command and a matching XOR checksum.
   function automatic logic frame_ok(input logic [BYTE_W-1:0] cmd, input logic [BYTE_W-1:0] d0,
                                     input logic [BYTE_W-1:0] d1, input logic [BYTE_W-1:0] chk);
      return (chk == (cmd ^ d0 ^ d1)) && (cmd >= CMD_SET_TRIG) && (cmd <= CMD_DEFAULTS);
   endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte gap counter; saturates and flags hit once TIMEOUT_CYC idle cycles have elapsed.
module cmd_timeout_timer #(
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter int unsigned TC_W        = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit_c
);

   logic [TC_W-1:0] count;

   assign hit_c = (count == TC_W'(TIMEOUT_CYC));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && !hit_c)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/scope_cmd_ctrl.sv
// Parses 5-byte UART command frames, owns the scope config registers and returns ACK/NACK.
module scope_cmd_ctrl
   import scope_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter int unsigned TC_W        = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_req,
   input  logic        tx_ack,
   output logic [7:0]  trig_level,
   output logic        trig_edge,
   output logic [15:0] timebase_div,
   output logic        arm,
   output logic        force_trig,
   output logic        busy,
   output logic        ovf
);

   state_t            state;
   logic [BYTE_W-1:0] cmd_q, d0_q, d1_q, chk_q;
   logic              in_frame_c;
   logic              tmo_clr_c;
   logic              tmo_hit_c;

   // The gap timer only runs while a frame is partially received.
   assign in_frame_c = (state == CMD) || (state == D0) || (state == D1) || (state == CHK);
   assign tmo_clr_c  = rx_valid || !in_frame_c;

   cmd_timeout_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TC_W        (TC_W)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (tmo_clr_c),
      .en    (in_frame_c),
      .hit_c (tmo_hit_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cmd_q        <= '0;
         d0_q         <= '0;
         d1_q         <= '0;
         chk_q        <= '0;
         tx_data      <= '0;
         tx_req       <= 1'b0;
         trig_level   <= DEF_LEVEL;
         trig_edge    <= DEF_EDGE;
         timebase_div <= DEF_DIV;
         arm          <= 1'b0;
         force_trig   <= 1'b0;
         busy         <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         arm        <= 1'b0;
         force_trig <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_valid && (rx_data == HDR)) begin
                  state <= CMD;
                  busy  <= 1'b1;
               end
            end
            // A byte arriving on the timeout cycle still advances the parser.
            CMD: begin
               if (rx_valid) begin
                  cmd_q <= rx_data;
                  state <= D0;
               end else if (tmo_hit_c) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            D0: begin
               if (rx_valid) begin
                  d0_q  <= rx_data;
                  state <= D1;
               end else if (tmo_hit_c) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            D1: begin
               if (rx_valid) begin
                  d1_q  <= rx_data;
                  state <= CHK;
               end else if (tmo_hit_c) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            CHK: begin
               if (rx_valid) begin
                  chk_q <= rx_data;
                  state <= EXEC;
               end else if (tmo_hit_c) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            EXEC: begin
               state  <= RESP;
               tx_req <= 1'b1;
               if (frame_ok(cmd_q, d0_q, d1_q, chk_q)) begin
                  tx_data <= ACK_BYTE;
                  case (cmd_q)
                     CMD_SET_TRIG: begin
                        trig_level <= d0_q;
                        trig_edge  <= d1_q[0];
                     end
                     CMD_SET_TB:   timebase_div <= {d1_q, d0_q};
                     CMD_ARM:      arm <= 1'b1;
                     CMD_FORCE:    force_trig <= 1'b1;
                     CMD_DEFAULTS: begin
                        trig_level   <= DEF_LEVEL;
                        trig_edge    <= DEF_EDGE;
                        timebase_div <= DEF_DIV;
                        ovf          <= 1'b0;
                     end
                     default: ;
                  endcase
               end else begin
                  tx_data <= NACK_BYTE;
               end
            end
            // Bytes arriving while the response is outstanding are dropped and flagged.
            RESP: begin
               if (rx_valid)
                  ovf <= 1'b1;
               if (tx_req && tx_ack) begin
                  tx_req <= 1'b0;
                  state  <= IDLE;
                  busy   <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               tx_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scope_cmd_ctrl.sv
// Directed plus randomized frames for scope_cmd_ctrl, checked against a frame-level reference model.
module tb_scope_cmd_ctrl;

   localparam int unsigned TMO = 100;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_req;
   logic        tx_ack;
   logic [7:0]  trig_level;
   logic        trig_edge;
   logic [15:0] timebase_div;
   logic        arm;
   logic        force_trig;
   logic        busy;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   // Reference state: what the scope configuration should be after each accepted frame.
   logic [7:0]  m_level;
   logic        m_edge;
   logic [15:0] m_div;
   logic        m_ovf;

   scope_cmd_ctrl #(
      .TIMEOUT_CYC (TMO),
      .TC_W        (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .tx_data      (tx_data),
      .tx_req       (tx_req),
      .tx_ack       (tx_ack),
      .trig_level   (trig_level),
      .trig_edge    (trig_edge),
      .timebase_div (timebase_div),
      .arm          (arm),
      .force_trig   (force_trig),
      .busy         (busy),
      .ovf          (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_level = 8'h80;
      m_edge  = 1'b0;
      m_div   = 16'h01B2;
      m_ovf   = 1'b0;
   endtask

   task automatic check_cfg(input string tag);
      chk({tag, "_level"}, 16'(trig_level), 16'(m_level));
      chk({tag, "_edge"},  16'(trig_edge),  16'(m_edge));
      chk({tag, "_div"},   timebase_div,    m_div);
      chk({tag, "_ovf"},   16'(ovf),        16'(m_ovf));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Full frame with gap idle cycles after the header, wait_cyc ack stall and n_ovf bytes during the response.
   task automatic run_frame(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] k, input int gap, input int wait_cyc, input int n_ovf);
      logic       ok;
      logic       exp_arm;
      logic       exp_force;
      logic [7:0] exp_resp;
      send_byte(8'hA5);
      repeat (gap) tick();
      send_byte(c);
      send_byte(d0);
      send_byte(d1);
      send_byte(k);
      chk("exec_busy",  16'(busy),   16'd1);
      chk("exec_txreq", 16'(tx_req), 16'd0);
      ok        = ((c ^ d0 ^ d1) == k) && (c >= 8'd1) && (c <= 8'd5);
      exp_arm   = ok && (c == 8'd3);
      exp_force = ok && (c == 8'd4);
      exp_resp  = ok ? 8'h06 : 8'h15;
      if (ok) begin
         if (c == 8'd1) begin
            m_level = d0;
            m_edge  = d1[0];
         end else if (c == 8'd2) begin
            m_div = {d1, d0};
         end else if (c == 8'd5) begin
            model_reset();
         end
      end
      if (wait_cyc == 0) tx_ack = 1'b1;
      tick();
      check_cfg("resp");
      chk("resp_arm",    16'(arm),        16'(exp_arm));
      chk("resp_force",  16'(force_trig), 16'(exp_force));
      chk("resp_txreq",  16'(tx_req),     16'd1);
      chk("resp_txdata", 16'(tx_data),    16'(exp_resp));
      chk("resp_busy",   16'(busy),       16'd1);
      if (wait_cyc == 0) begin
         tick();
         tx_ack = 1'b0;
         chk("fast_txreq", 16'(tx_req),     16'd0);
         chk("fast_busy",  16'(busy),       16'd0);
         chk("fast_arm",   16'(arm),        16'd0);
         chk("fast_force", 16'(force_trig), 16'd0);
      end else begin
         tick();
         chk("pulse_arm",   16'(arm),        16'd0);
         chk("pulse_force", 16'(force_trig), 16'd0);
         for (int i = 0; i < n_ovf; i++) begin
            send_byte(8'($urandom));
            m_ovf = 1'b1;
         end
         repeat (wait_cyc) tick();
         chk("hold_txreq",  16'(tx_req),  16'd1);
         chk("hold_txdata", 16'(tx_data), 16'(exp_resp));
         chk("hold_ovf",    16'(ovf),     16'(m_ovf));
         tx_ack = 1'b1;
         tick();
         tx_ack = 1'b0;
         chk("ack_txreq", 16'(tx_req), 16'd0);
         chk("ack_busy",  16'(busy),   16'd0);
         chk("ack_ovf",   16'(ovf),    16'(m_ovf));
      end
   endtask

   initial begin
      logic [7:0] c, d0, d1, k, junk;
      int         gap;
      int         wt;
      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ack   = 1'b0;
      model_reset();
      #2;
      check_cfg("rst");
      chk("rst_txreq",  16'(tx_req),     16'd0);
      chk("rst_txdata", 16'(tx_data),    16'd0);
      chk("rst_busy",   16'(busy),       16'd0);
      chk("rst_arm",    16'(arm),        16'd0);
      chk("rst_force",  16'(force_trig), 16'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Directed frames
      run_frame(8'h01, 8'h40, 8'h01, 8'h40, 0, 2, 0);
      run_frame(8'h02, 8'hE8, 8'h03, 8'hE9, 0, 0, 0);
      run_frame(8'h05, 8'h00, 8'h00, 8'h05, 0, 1, 0);
      run_frame(8'h01, 8'h40, 8'h01, 8'h00, 0, 1, 0);
      run_frame(8'h07, 8'h00, 8'h00, 8'h07, 0, 0, 0);

      // Partial frame abandoned by the inter-byte timeout
      send_byte(8'hA5);
      send_byte(8'h01);
      repeat (TMO) tick();
      chk("tmo_edge_busy", 16'(busy), 16'd1);
      tick();
      chk("tmo_busy",  16'(busy),   16'd0);
      chk("tmo_txreq", 16'(tx_req), 16'd0);
      check_cfg("tmo");
      run_frame(8'h03, 8'h00, 8'h00, 8'h03, 0, 0, 0);

      // Byte landing exactly on the timeout cycle keeps the frame alive
      run_frame(8'h02, 8'h34, 8'h12, 8'h24, TMO, 1, 0);

      // Overflow during a stalled response, cleared by DEFAULTS
      run_frame(8'h04, 8'h00, 8'h00, 8'h04, 0, 4, 2);
      run_frame(8'h05, 8'h00, 8'h00, 8'h05, 0, 1, 0);

      // Asynchronous reset in the middle of a frame
      run_frame(8'h01, 8'h33, 8'h01, 8'h33, 0, 0, 0);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'hE8);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_cfg("arst");
      chk("arst_busy",  16'(busy),   16'd0);
      chk("arst_txreq", 16'(tx_req), 16'd0);
      tick();
      rst = 1'b0;
      tick();
      send_byte(8'h03);
      send_byte(8'hE9);
      repeat (4) tick();
      chk("post_rst_txreq", 16'(tx_req), 16'd0);
      chk("post_rst_busy",  16'(busy),   16'd0);
      check_cfg("post_rst");

      // Randomized frames with stray bytes, gaps, ack stalls and overflow
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            junk = 8'($urandom);
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk);
            chk("junk_busy", 16'(busy), 16'd0);
         end
         c  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(1, 5));
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         k  = c ^ d0 ^ d1;
         if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
         gap = ($urandom_range(0, 9) == 0) ? int'(TMO) : int'($urandom_range(0, 3));
         wt  = int'($urandom_range(0, 3));
         run_frame(c, d0, d1, k, gap, wt, (wt > 0) ? int'($urandom_range(0, 2)) : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scope_cmd_ctrl.md
# scope_cmd_ctrl

Command controller between the UART byte receiver and the scope capture/trigger logic. Consumes received bytes as one-cycle strobes and parses fixed 5-byte command frames. On a valid frame it updates the scope configuration registers or issues arm/force pulses. It returns a one-byte ACK/NACK to the UART transmit path over a req/ack handshake.

## Interface
Parameters:
- TIMEOUT_CYC, 500000, inter-byte gap (clk cycles) that aborts a partial frame
- TC_W, 20, timeout counter width; must satisfy 2^TC_W > TIMEOUT_CYC

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received byte; valid only while rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- tx_data  out  8  response byte (0x06 ACK, 0x15 NACK)
- tx_req  out  1  response pending; held until accepted
- tx_ack  in  1  transmitter accepts tx_data when tx_req&tx_ack
- trig_level  out  8  trigger threshold
- trig_edge  out  1  0 rising, 1 falling
- timebase_div  out  16  sample clock divisor
- arm  out  1  one-cycle capture arm pulse
- force_trig  out  1  one-cycle forced trigger pulse
- busy  out  1  high whenever state != IDLE
- ovf  out  1  sticky: byte arrived while in RESP

## Operation
- Frame: 0xA5, CMD, D0, D1, CHK. Checksum rule: CHK == CMD^D0^D1.
- Commands:
  - 0x01 SET_TRIG: trig_level=D0, trig_edge=D1[0].
  - 0x02 SET_TB: timebase_div={D1,D0}.
  - 0x03 ARM: arm pulse.
  - 0x04 FORCE: force_trig pulse.
  - 0x05 DEFAULTS: all config registers to reset values; ovf cleared.
- Unknown CMD or bad CHK: NACK. No register change, no pulse.
- States and transitions:
  - IDLE→CMD on rx_valid with rx_data==0xA5. Any other byte is ignored.
  - CMD→D0→D1→CHK, each advancing on rx_valid. The byte value is not checked, so 0xA5 is legal data.
  - CHK→EXEC on rx_valid (CHK byte latched).
  - EXEC→RESP unconditionally after one cycle.
  - RESP→IDLE on tx_req&tx_ack.
- Timeout: counter clears on every rx_valid and in IDLE/EXEC/RESP. If it reaches TIMEOUT_CYC while in CMD..CHK, go to IDLE with no response and no register change.
- rx_valid in RESP: byte discarded, ovf←1. The parser does not restart until RESP exits.
- Reset values:
  - trig_level=0x80, trig_edge=0, timebase_div=0x01B2
  - arm=0, force_trig=0, tx_req=0, tx_data=0x00, ovf=0, busy=0, state=IDLE
- Reset mid-frame aborts immediately; no response is emitted after reset release.

## Timing
- CHK strobe in cycle t → EXEC in cycle t+1.
- In cycle t+2:
  - register updates visible
  - arm/force_trig high for exactly one cycle (t+2 only)
  - tx_req=1 with stable tx_data; state is RESP.
- tx_req and tx_data are held until tx_ack is sampled high. tx_req drops the cycle after acceptance.
- tx_ack already high at t+2 is accepted at t+2: tx_req is high one cycle, and IDLE holds at t+3.
- Throughput: the first byte of the next frame is accepted from the cycle IDLE is entered.
- rx_valid coincident with a timeout hit: the byte wins. The counter clears and the state advances.
- Minimum frame-to-response latency: 2 cycles after the CHK strobe.

## Structure
- Shared package scope_cmd_pkg holds:
  - header 0xA5
  - CMD codes 0x01–0x05
  - ACK 0x06, NACK 0x15
  - reset defaults (0x80, 0, 0x01B2)
  - state enum IDLE, CMD, D0, D1, CHK, EXEC, RESP (3-bit encoding)
- Sub-module cmd_timeout_timer: TC_W-bit counter with clear and enable inputs, and a hit output at TIMEOUT_CYC.
- Parser FSM, config registers and response logic stay in the top module.
- Bench parameter: TIMEOUT_CYC=100.

## Test plan
- SET_TRIG frame A5 01 40 01 40 → trig_level=0x40, trig_edge=1 at t+2; tx_req with tx_data=0x06; tx_ack → tx_req low next cycle.
- SET_TB frame A5 02 E8 03 E9 → timebase_div=0x03E8, ACK. Then A5 05 00 00 05 → timebase_div=0x01B2, trig_level=0x80, ACK.
- Bad checksum A5 01 40 01 00 → registers unchanged, tx_data=0x15. Unknown command A5 07 00 00 07 → NACK.
- Timeout abort: A5 01, then a 100-cycle gap → busy low, no tx_req. Then A5 03 00 00 03 → arm high exactly one cycle at t+2, ACK.
- Overflow: frame A5 04 00 00 04 with tx_ack held low; two bytes sent during RESP → ovf=1, force_trig pulsed once, and ovf stays set after the ack. A DEFAULTS frame then clears ovf.
- Async reset asserted after A5 02 E8 → all outputs return to reset values immediately. After release, the trailing 03 E9 bytes produce no response and no register change.
